// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller for the five-stage MIPS core.
// Merges ID/EX/MEM stall requests into the StallBus vector, sequences
// one-cycle exception flushes with a redirect PC, and watches for a hung
// data-memory wait.
// Optional feature macro: PIPE_CTRL_PERF_EN adds four CNT_W-bit wrapping
// performance counters (CNT_W must be <= 32) readable through
// perf_sel/perf_data. Without it perf_data reads 0.
module pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        except_req,
  input  logic [31:0] except_pc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        mem_timeout,
  input  logic [1:0]  perf_sel,
  output logic [31:0] perf_data
);

  // Bit i holds stage i: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
  typedef logic [5:0] stall_bus_t;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  // The single reason that decides this cycle's stall vector.
  typedef enum logic [2:0] {
    C_NONE,
    C_ID,
    C_EX,
    C_MEM,
    C_ACCEPT,
    C_FLUSH
  } cause_t;

  localparam stall_bus_t  LP_STALL_NONE = 6'b000000;
  localparam stall_bus_t  LP_STALL_ID   = 6'b000111;
  localparam stall_bus_t  LP_STALL_EX   = 6'b001111;
  localparam stall_bus_t  LP_STALL_MEM  = 6'b011111;
  localparam logic [15:0] LP_TIMEOUT    = 16'(MEM_TIMEOUT);

  state_t      r_state;
  logic        r_flush;
  logic [31:0] r_new_pc;
  logic [15:0] r_mem_wait;
  logic        r_mem_timeout;

  cause_t      w_cause;
  stall_bus_t  w_stall;
  logic        w_accept;
  logic [15:0] w_mem_wait_nxt;

  // Classify the cycle: FLUSH masks everything, then MEM beats a pending
  // exception (deferral), an exception beats EX/ID, EX beats ID.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    w_cause = C_NONE;
    if (r_state == S_FLUSH) begin
      w_cause = C_FLUSH;
    end else if (stallreq_mem) begin
      w_cause = C_MEM;
    end else if (except_req) begin
      w_cause = C_ACCEPT;
    end else if (stallreq_ex) begin
      w_cause = C_EX;
    end else if (stallreq_id) begin
      w_cause = C_ID;
    end
  end

  assign w_accept = (w_cause == C_ACCEPT);

  // Translate the winning cause into the stall vector; the accept cycle
  // freezes everything up to MEM so the faulting instruction stays put.
  always_comb begin
    w_stall = LP_STALL_NONE;
    case (w_cause)
      C_MEM,
      C_ACCEPT: w_stall = LP_STALL_MEM;
      C_EX:     w_stall = LP_STALL_EX;
      C_ID:     w_stall = LP_STALL_ID;
      default:  w_stall = LP_STALL_NONE;
    endcase
  end

  // Exception sequencer: accept in RUN, one registered FLUSH cycle, back to RUN.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state  <= S_RUN;
      r_flush  <= 1'b0;
      r_new_pc <= 32'h0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_accept) begin
            r_state  <= S_FLUSH;
            r_flush  <= 1'b1;
            r_new_pc <= except_pc;
          end
        end
        S_FLUSH: begin
          r_state <= S_RUN;
          r_flush <= 1'b0;
        end
        default: begin
          r_state <= S_RUN;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  // Next wait count: counts MEM-stall cycles in RUN, saturating at the limit.
  always_comb begin
    w_mem_wait_nxt = 16'h0;
    if (r_state == S_RUN && stallreq_mem) begin
      w_mem_wait_nxt = (r_mem_wait == LP_TIMEOUT) ? r_mem_wait : r_mem_wait + 16'd1;
    end
  end

  // Watchdog: the flag sets on the edge where the count reaches the limit
  // and stays set until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_wait    <= 16'h0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_mem_wait <= w_mem_wait_nxt;
      if (w_mem_wait_nxt == LP_TIMEOUT) begin
        r_mem_timeout <= 1'b1;
      end
    end
  end

  assign stall       = w_stall;
  assign flush       = r_flush;
  assign new_pc      = r_new_pc;
  assign mem_timeout = r_mem_timeout;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_perf_cnt [4];

  // Count each cycle once, under its winning cause; accept cycles count nowhere.
  always_ff @(posedge clk) begin
    // NOTE: this small counter array is built from flops and must read 0
    // after reset, so it is reset explicitly; a RAM-style array would not be.
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_perf_cnt[i] <= '0;
      end
    end else begin
      case (w_cause)
        C_ID:    r_perf_cnt[0] <= r_perf_cnt[0] + CNT_W'(1);
        C_EX:    r_perf_cnt[1] <= r_perf_cnt[1] + CNT_W'(1);
        C_MEM:   r_perf_cnt[2] <= r_perf_cnt[2] + CNT_W'(1);
        C_FLUSH: r_perf_cnt[3] <= r_perf_cnt[3] + CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign perf_data = 32'(r_perf_cnt[perf_sel]);
`else
  localparam int unsigned LP_UNUSED_CNT_W = CNT_W;
  logic w_unused_perf_sel;

  assign w_unused_perf_sel = ^perf_sel;
  assign perf_data         = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed test-plan sequences plus
// randomized traffic, all scored against a cycle-level reference model.
module tb_pipe_ctrl;

  localparam int unsigned M = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id  = 1'b0;
  logic        ex  = 1'b0;
  logic        mem = 1'b0;
  logic        exc = 1'b0;
  logic [31:0] epc = 32'h0;
  logic [1:0]  sel = 2'd0;

  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mto;
  logic [31:0] perf_data;

  pipe_ctrl #(.MEM_TIMEOUT(M), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (id),
    .stallreq_ex  (ex),
    .stallreq_mem (mem),
    .except_req   (exc),
    .except_pc    (epc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .mem_timeout  (mto),
    .perf_sel     (sel),
    .perf_data    (perf_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        to;
    logic [31:0] perf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state, in terms of observable behaviour.
  bit          m_known    = 1'b0;
  bit          m_in_flush = 1'b0;
  logic [31:0] m_pc       = 32'h0;
  int          m_wait     = 0;
  bit          m_to       = 1'b0;
  int unsigned m_cnt [4]  = '{0, 0, 0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Outputs expected during the current cycle, given present model state and inputs.
  function automatic exp_t model_expect();
    exp_t e;
    if (m_in_flush)      e.stall = 6'b000000;
    else if (mem || exc) e.stall = 6'b011111;
    else if (ex)         e.stall = 6'b001111;
    else if (id)         e.stall = 6'b000111;
    else                 e.stall = 6'b000000;
    e.flush  = m_in_flush;
    e.new_pc = m_pc;
    e.to     = m_to;
`ifdef PIPE_CTRL_PERF_EN
    e.perf = m_cnt[sel];
`else
    e.perf = 32'h0;
`endif
    return e;
  endfunction

  // Advance the model across one rising edge.
  task automatic model_step();
    bit accept;
    if (rst) begin
      m_known    = 1'b1;
      m_in_flush = 1'b0;
      m_pc       = 32'h0;
      m_wait     = 0;
      m_to       = 1'b0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      return;
    end
    accept = !m_in_flush && exc && !mem;
    if (m_in_flush)         m_cnt[3]++;
    else if (mem)           m_cnt[2]++;
    else if (!exc && ex)    m_cnt[1]++;
    else if (!exc && id)    m_cnt[0]++;
    if (m_in_flush || !mem) m_wait = 0;
    else if (m_wait < int'(M)) m_wait++;
    if (m_wait == int'(M))  m_to = 1'b1;
    if (accept)             m_pc = epc;
    m_in_flush = accept;
  endtask

  // Apply one cycle of inputs at the falling edge and queue the expected response.
  task automatic drive(input bit r, input bit i_id, input bit i_ex, input bit i_mem,
                       input bit i_exc, input logic [31:0] i_epc, input logic [1:0] i_sel);
    @(negedge clk);
    rst = r; id = i_id; ex = i_ex; mem = i_mem; exc = i_exc; epc = i_epc; sel = i_sel;
    if (m_known) sb.push_back(model_expect());
    model_step();
  endtask

  // Monitor: compares DUT outputs against queued expectations mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_stall",  32'(stall),     32'(e.stall));
        check("sb_flush",  32'(flush),     32'(e.flush));
        check("sb_new_pc", new_pc,         e.new_pc);
        check("sb_mto",    32'(mto),       32'(e.to));
        check("sb_perf",   perf_data,      e.perf);
      end
    end
  end

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    bit mem_r;
    bit exc_r;

    // Reset then idle.
    drive(1, 0, 0, 0, 0, 32'h0, 2'd0);
    drive(1, 0, 0, 0, 0, 32'h0, 2'd0);
    repeat (3) drive(0, 0, 0, 0, 0, 32'h0, 2'd0);
    #3;
    check("idle_stall",  32'(stall), 32'h0);
    check("idle_flush",  32'(flush), 32'h0);
    check("idle_new_pc", new_pc,     32'h0);
    check("idle_mto",    32'(mto),   32'h0);

    // Single-cycle load-use stall.
    drive(0, 1, 0, 0, 0, 32'h0, 2'd0);
    #3 check("id_stall", 32'(stall), 32'h07);
    drive(0, 0, 0, 0, 0, 32'h0, 2'd0);
    #3 check("id_release", 32'(stall), 32'h00);
`ifdef PIPE_CTRL_PERF_EN
    check("perf_id_count", perf_data, 32'd1);
`endif

    // Priority: all three, then drop MEM, then drop EX.
    drive(0, 1, 1, 1, 0, 32'h0, 2'd2);
    #3 check("prio_all", 32'(stall), 32'h1f);
    drive(0, 1, 1, 0, 0, 32'h0, 2'd1);
    #3 check("prio_ex_id", 32'(stall), 32'h0f);
    drive(0, 1, 0, 0, 0, 32'h0, 2'd0);
    #3 check("prio_id", 32'(stall), 32'h07);
    drive(0, 0, 0, 0, 0, 32'h0, 2'd3);

    // Exception accept, flush, return; request still held during FLUSH.
    drive(0, 1, 1, 0, 1, 32'hBFC00380, 2'd0);
    #3 check("exc_accept_stall", 32'(stall), 32'h1f);
    check("exc_accept_flush", 32'(flush), 32'h0);
    drive(0, 1, 0, 0, 1, 32'h12345678, 2'd3);
    #3 check("exc_flush", 32'(flush), 32'h1);
    check("exc_new_pc", new_pc, 32'hBFC00380);
    check("exc_flush_stall", 32'(stall), 32'h00);
    drive(0, 0, 0, 0, 0, 32'h0, 2'd3);
    #3 check("exc_flush_done", 32'(flush), 32'h0);

    // Exception deferred behind a 3-cycle MEM stall.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 1, 32'h80000180, 2'd2);
      #3 check("defer_flush", 32'(flush), 32'h0);
      check("defer_stall", 32'(stall), 32'h1f);
    end
    drive(0, 0, 0, 0, 1, 32'h80000180, 2'd2);
    #3 check("defer_accept_flush", 32'(flush), 32'h0);
    drive(0, 0, 0, 0, 1, 32'h80000180, 2'd3);
    #3 check("defer_flush_on", 32'(flush), 32'h1);
    check("defer_new_pc", new_pc, 32'h80000180);
    drive(0, 0, 0, 0, 0, 32'h0, 2'd0);

    // Watchdog: MEM held 10 cycles with limit 4, then released, then reset.
    drive(1, 0, 0, 0, 0, 32'h0, 2'd0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 1, 0, 32'h0, 2'd2);
      #3 check("wd_ramp", 32'(mto), 32'(i >= int'(M)));
    end
    drive(0, 0, 0, 0, 0, 32'h0, 2'd2);
    #3 check("wd_sticky", 32'(mto), 32'h1);
    check("wd_no_stall", 32'(stall), 32'h0);
    drive(0, 0, 0, 0, 0, 32'h0, 2'd2);
    #3 check("wd_sticky2", 32'(mto), 32'h1);
    drive(1, 0, 0, 0, 0, 32'h0, 2'd0);
    drive(0, 0, 0, 0, 0, 32'h0, 2'd0);
    #3 check("wd_cleared", 32'(mto), 32'h0);

    // Randomized traffic, including resets that may land in FLUSH.
    mem_r = 1'b0;
    exc_r = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) mem_r = ~mem_r;
      exc_r = ($urandom_range(0, 5) == 0);
      drive(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0),
            mem_r, exc_r, $urandom, 2'($urandom_range(0, 3)));
    end
    drive(0, 0, 0, 0, 0, 32'h0, 2'd0);

    // Let the monitor drain, bounded.
    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
    #4 check("sb_drain", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
